// File: rtl/regfile_sequencer_if.sv
// Command handshake between the instruction decoder (master) and the
// register-file sequencer (slave): one register-transfer command per
// CMD_VALID/CMD_READY handshake.
interface regfile_sequencer_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic [2:0] CMD_OP;
    logic [2:0] CMD_SRC;
    logic [2:0] CMD_SRC2;
    logic [2:0] CMD_DST;

    modport master (output CMD_VALID, CMD_OP, CMD_SRC, CMD_SRC2, CMD_DST,
                    input  CMD_READY);
    modport slave  (input  CMD_VALID, CMD_OP, CMD_SRC, CMD_SRC2, CMD_DST,
                    output CMD_READY);
endinterface

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: expands one register-transfer command into a 1- or
// 2-cycle sequence of registered register-file / memory / ALU strobes.
// Optional feature: define REGSEQ_ILLEGAL_TRAP_EN to make op 7 trap (sticky
// ILLEGAL, sequencer locked until reset); otherwise op 7 behaves as NOP.
// Every output is a flop: the comb logic computes the value each output
// will hold in the next state, and that value is registered on the edge.
module regfile_sequencer (
    input  logic                       CLK,
    input  logic                       RST_bar,
    regfile_sequencer_if.slave         cmd,
    output logic                       DONE,
    output logic                       ILLEGAL,
    output logic                       MAIN_ASSERT_bar,
    output logic                       MAIN_LOAD_bar,
    output logic                       LHS_ASSERT_bar,
    output logic                       RHS_ASSERT_bar,
    output logic                       ADDR_ASSERT_bar,
    output logic                       ADDR_LOAD_bar,
    output logic                       ADDR_INC,
    output logic [2:0]                 MAIN_ASSERT_SEL,
    output logic [2:0]                 MAIN_LOAD_SEL,
    output logic [2:0]                 LHS_ASSERT_SEL,
    output logic [2:0]                 RHS_ASSERT_SEL,
    output logic [2:0]                 ADDR_ASSERT_SEL,
    output logic [2:0]                 ADDR_LOAD_SEL,
    output logic [2:0]                 ADDR_INC_SEL,
    output logic                       MEM_READ_bar,
    output logic                       MEM_WRITE_bar,
    output logic                       ALU_ASSERT_bar
);
    typedef enum logic [2:0] {S_IDLE, S_EXEC1, S_EXEC2, S_DONE, S_TRAP} state_t;

    localparam logic [2:0] OP_NOP = 3'd0, OP_MOV8 = 3'd1, OP_MOV16 = 3'd2,
                           OP_INC16 = 3'd3, OP_ALU = 3'd4, OP_FETCH = 3'd5,
                           OP_STORE = 3'd6, OP_RSVD = 3'd7;

    // Control word; active-low strobes are stored already inverted.
    typedef struct packed {
        logic       main_assert_bar, main_load_bar, lhs_assert_bar, rhs_assert_bar;
        logic       addr_assert_bar, addr_load_bar, addr_inc;
        logic [2:0] main_assert_sel, main_load_sel, lhs_assert_sel, rhs_assert_sel;
        logic [2:0] addr_assert_sel, addr_load_sel, addr_inc_sel;
        logic       mem_read_bar, mem_write_bar, alu_assert_bar;
    } ctl_t;

    localparam ctl_t CTL_IDLE = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                                  3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0,
                                  1'b1, 1'b1, 1'b1};

    state_t     state_q, state_d;
    ctl_t       ctl_q, ctl_d;
    logic       ready_q, done_q;
    logic [2:0] op_q, src_q, src2_q, dst_q;
    logic [2:0] op_c, src_c, src2_c, dst_c;
    logic       accept;

    assign accept = cmd.CMD_VALID && ready_q;

    // The command driving next-cycle strobes: the one being accepted now,
    // otherwise the latched one.
    assign op_c   = accept ? cmd.CMD_OP   : op_q;
    assign src_c  = accept ? cmd.CMD_SRC  : src_q;
    assign src2_c = accept ? cmd.CMD_SRC2 : src2_q;
    assign dst_c  = accept ? cmd.CMD_DST  : dst_q;

    // State register.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Command latch, loaded only on a handshake.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            op_q <= OP_NOP; src_q <= 3'd0; src2_q <= 3'd0; dst_q <= 3'd0;
        end else if (accept) begin
            op_q <= cmd.CMD_OP; src_q <= cmd.CMD_SRC;
            src2_q <= cmd.CMD_SRC2; dst_q <= cmd.CMD_DST;
        end
    end

    // Next-state: IDLE -> EXEC1 [-> EXEC2] -> DONE -> IDLE, or TRAP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) begin
`ifdef REGSEQ_ILLEGAL_TRAP_EN
                state_d = (cmd.CMD_OP == OP_RSVD) ? S_TRAP : S_EXEC1;
`else
                state_d = S_EXEC1;
`endif
            end
            S_EXEC1: state_d = (op_q == OP_FETCH || op_q == OP_STORE) ? S_EXEC2 : S_DONE;
            S_EXEC2: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
    end

    // Next-cycle outputs decoded from the next state and command.
    always_comb begin
        ctl_d = CTL_IDLE;
        if (state_d == S_EXEC1 || state_d == S_EXEC2) begin
            case (op_c)
                OP_MOV8: begin
                    ctl_d.main_assert_bar = 1'b0; ctl_d.main_assert_sel = src_c;
                    ctl_d.main_load_bar   = 1'b0; ctl_d.main_load_sel   = dst_c;
                end
                OP_MOV16: begin
                    ctl_d.addr_assert_bar = 1'b0; ctl_d.addr_assert_sel = src_c;
                    ctl_d.addr_load_bar   = 1'b0; ctl_d.addr_load_sel   = dst_c;
                end
                OP_INC16: begin
                    ctl_d.addr_inc = 1'b1; ctl_d.addr_inc_sel = dst_c;
                end
                OP_ALU: begin
                    ctl_d.lhs_assert_bar = 1'b0; ctl_d.lhs_assert_sel = src_c;
                    ctl_d.rhs_assert_bar = 1'b0; ctl_d.rhs_assert_sel = src2_c;
                    ctl_d.alu_assert_bar = 1'b0;
                    ctl_d.main_load_bar  = 1'b0; ctl_d.main_load_sel  = dst_c;
                end
                OP_FETCH: begin
                    ctl_d.addr_assert_bar = 1'b0; ctl_d.addr_assert_sel = src_c;
                    ctl_d.mem_read_bar    = 1'b0;
                    // Second cycle loads the data and post-increments the pointer.
                    if (state_d == S_EXEC2) begin
                        ctl_d.main_load_bar = 1'b0; ctl_d.main_load_sel = dst_c;
                        ctl_d.addr_inc      = 1'b1; ctl_d.addr_inc_sel  = src_c;
                    end
                end
                OP_STORE: begin
                    ctl_d.addr_assert_bar = 1'b0; ctl_d.addr_assert_sel = src_c;
                    ctl_d.main_assert_bar = 1'b0; ctl_d.main_assert_sel = src2_c;
                    // Write strobe only once address and data have settled.
                    if (state_d == S_EXEC2) ctl_d.mem_write_bar = 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Output registers.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar) begin
            ctl_q   <= CTL_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            ctl_q   <= ctl_d;
            ready_q <= (state_d == S_IDLE);
            done_q  <= (state_d == S_DONE);
        end
    end

`ifdef REGSEQ_ILLEGAL_TRAP_EN
    logic illegal_q;
    // Sticky trap flag, cleared only by reset.
    always_ff @(posedge CLK or negedge RST_bar) begin
        if (!RST_bar)              illegal_q <= 1'b0;
        else if (state_d == S_TRAP) illegal_q <= 1'b1;
    end
    assign ILLEGAL = illegal_q;
`else
    assign ILLEGAL = 1'b0;
`endif

    assign cmd.CMD_READY   = ready_q;
    assign DONE            = done_q;
    assign MAIN_ASSERT_bar = ctl_q.main_assert_bar;
    assign MAIN_LOAD_bar   = ctl_q.main_load_bar;
    assign LHS_ASSERT_bar  = ctl_q.lhs_assert_bar;
    assign RHS_ASSERT_bar  = ctl_q.rhs_assert_bar;
    assign ADDR_ASSERT_bar = ctl_q.addr_assert_bar;
    assign ADDR_LOAD_bar   = ctl_q.addr_load_bar;
    assign ADDR_INC        = ctl_q.addr_inc;
    assign MAIN_ASSERT_SEL = ctl_q.main_assert_sel;
    assign MAIN_LOAD_SEL   = ctl_q.main_load_sel;
    assign LHS_ASSERT_SEL  = ctl_q.lhs_assert_sel;
    assign RHS_ASSERT_SEL  = ctl_q.rhs_assert_sel;
    assign ADDR_ASSERT_SEL = ctl_q.addr_assert_sel;
    assign ADDR_LOAD_SEL   = ctl_q.addr_load_sel;
    assign ADDR_INC_SEL    = ctl_q.addr_inc_sel;
    assign MEM_READ_bar    = ctl_q.mem_read_bar;
    assign MEM_WRITE_bar   = ctl_q.mem_write_bar;
    assign ALU_ASSERT_bar  = ctl_q.alu_assert_bar;
endmodule

// File: tb/tb_regfile_sequencer.sv
// Directed bench for regfile_sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge. Strobes are compared as a 10-bit
// word {MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar,
// ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC, MEM_READ_bar, MEM_WRITE_bar,
// ALU_ASSERT_bar}; selects as a 21-bit word {MAIN_ASSERT, MAIN_LOAD, LHS,
// RHS, ADDR_ASSERT, ADDR_LOAD, ADDR_INC}_SEL.
module tb_regfile_sequencer;
    logic CLK = 1'b0;
    logic RST_bar;
    logic DONE, ILLEGAL;
    logic MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar;
    logic ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC;
    logic [2:0] MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL;
    logic [2:0] ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL;
    logic MEM_READ_bar, MEM_WRITE_bar, ALU_ASSERT_bar;

    int total = 0;
    int bad   = 0;

    localparam logic [9:0]  B_IDLE = 10'b1111110111;
    localparam logic [20:0] S_ZERO = 21'd0;

    regfile_sequencer_if cmd ();

    regfile_sequencer dut (
        .CLK(CLK), .RST_bar(RST_bar), .cmd(cmd.slave),
        .DONE(DONE), .ILLEGAL(ILLEGAL),
        .MAIN_ASSERT_bar(MAIN_ASSERT_bar), .MAIN_LOAD_bar(MAIN_LOAD_bar),
        .LHS_ASSERT_bar(LHS_ASSERT_bar), .RHS_ASSERT_bar(RHS_ASSERT_bar),
        .ADDR_ASSERT_bar(ADDR_ASSERT_bar), .ADDR_LOAD_bar(ADDR_LOAD_bar),
        .ADDR_INC(ADDR_INC),
        .MAIN_ASSERT_SEL(MAIN_ASSERT_SEL), .MAIN_LOAD_SEL(MAIN_LOAD_SEL),
        .LHS_ASSERT_SEL(LHS_ASSERT_SEL), .RHS_ASSERT_SEL(RHS_ASSERT_SEL),
        .ADDR_ASSERT_SEL(ADDR_ASSERT_SEL), .ADDR_LOAD_SEL(ADDR_LOAD_SEL),
        .ADDR_INC_SEL(ADDR_INC_SEL),
        .MEM_READ_bar(MEM_READ_bar), .MEM_WRITE_bar(MEM_WRITE_bar),
        .ALU_ASSERT_bar(ALU_ASSERT_bar)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [9:0] bars();
        return {MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar,
                ADDR_ASSERT_bar, ADDR_LOAD_bar, ADDR_INC, MEM_READ_bar,
                MEM_WRITE_bar, ALU_ASSERT_bar};
    endfunction

    function automatic logic [20:0] sels();
        return {MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL,
                ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL};
    endfunction

    // One cycle's full observation: strobes, selects, READY and DONE.
    task automatic look(input string tag, input logic [9:0] b, input logic [20:0] s,
                        input logic rdy, input logic dn);
        chk({tag, ".bars"}, {22'd0, bars()}, {22'd0, b});
        chk({tag, ".sels"}, {11'd0, sels()}, {11'd0, s});
        chk({tag, ".ready"}, {31'd0, cmd.CMD_READY}, {31'd0, rdy});
        chk({tag, ".done"}, {31'd0, DONE}, {31'd0, dn});
    endtask

    task automatic issue(input logic [2:0] op, input logic [2:0] src,
                         input logic [2:0] src2, input logic [2:0] dst);
        cmd.CMD_VALID = 1'b1; cmd.CMD_OP = op; cmd.CMD_SRC = src;
        cmd.CMD_SRC2 = src2; cmd.CMD_DST = dst;
    endtask

    // Selects word helper: {mas, mls, lhs, rhs, aas, als, ais}.
    function automatic logic [20:0] sw(input logic [2:0] mas, mls, lhs, rhs, aas, als, ais);
        return {mas, mls, lhs, rhs, aas, als, ais};
    endfunction

    initial begin
        RST_bar = 1'b0;
        issue(3'd1, 3'd2, 3'd0, 3'd1);              // MOV8 src=2 dst=1, valid during reset
        @(negedge CLK); @(negedge CLK);
        look("rst", B_IDLE, S_ZERO, 1'b1, 1'b0);
        chk("rst.illegal", {31'd0, ILLEGAL}, 32'd0);
        RST_bar = 1'b1;

        // MOV8 accepted on the first edge after release.
        @(negedge CLK);
        look("mov8.e1", 10'b0011110111, sw(2, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        cmd.CMD_VALID = 1'b0;
        @(negedge CLK); look("mov8.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK); look("mov8.idle", B_IDLE, S_ZERO, 1'b1, 1'b0);

        // FETCH src=0 dst=3.
        issue(3'd5, 3'd0, 3'd0, 3'd3);
        @(negedge CLK); cmd.CMD_VALID = 1'b0;
        look("fetch.e1", 10'b1111010011, S_ZERO, 1'b0, 1'b0);
        @(negedge CLK); look("fetch.e2", 10'b1011011011, sw(0, 3, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        @(negedge CLK); look("fetch.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK); look("fetch.idle", B_IDLE, S_ZERO, 1'b1, 1'b0);

        // STORE src=1 src2=2.
        issue(3'd6, 3'd1, 3'd2, 3'd5);
        @(negedge CLK); cmd.CMD_VALID = 1'b0;
        look("store.e1", 10'b0111010111, sw(2, 0, 0, 0, 1, 0, 0), 1'b0, 1'b0);
        @(negedge CLK); look("store.e2", 10'b0111010101, sw(2, 0, 0, 0, 1, 0, 0), 1'b0, 1'b0);
        @(negedge CLK); look("store.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK); look("store.idle", B_IDLE, S_ZERO, 1'b1, 1'b0);

        // MOV16 src=4 dst=7 (upper indices pass through).
        issue(3'd2, 3'd4, 3'd1, 3'd7);
        @(negedge CLK); cmd.CMD_VALID = 1'b0;
        look("mov16.e1", 10'b1111000111, sw(0, 0, 0, 0, 4, 7, 0), 1'b0, 1'b0);
        @(negedge CLK); look("mov16.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK);

        // INC16 dst=5.
        issue(3'd3, 3'd6, 3'd2, 3'd5);
        @(negedge CLK); cmd.CMD_VALID = 1'b0;
        look("inc16.e1", 10'b1111111111, sw(0, 0, 0, 0, 0, 0, 5), 1'b0, 1'b0);
        @(negedge CLK); look("inc16.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK);

        // NOP.
        issue(3'd0, 3'd7, 3'd7, 3'd7);
        @(negedge CLK); cmd.CMD_VALID = 1'b0;
        look("nop.e1", B_IDLE, S_ZERO, 1'b0, 1'b0);
        @(negedge CLK); look("nop.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK); look("nop.idle", B_IDLE, S_ZERO, 1'b1, 1'b0);

        // VALID held: MOV8 src=src=dst=1, then ALU changed mid-command must
        // wait for IDLE.
        issue(3'd1, 3'd1, 3'd0, 3'd1);
        @(negedge CLK);
        look("b2b.mov8", 10'b0011110111, sw(1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0);
        issue(3'd4, 3'd3, 3'd6, 3'd2);
        @(negedge CLK); look("b2b.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK); look("b2b.idle", B_IDLE, S_ZERO, 1'b1, 1'b0);
        @(negedge CLK); cmd.CMD_VALID = 1'b0;
        look("alu.e1", 10'b1000110110, sw(0, 2, 3, 6, 0, 0, 0), 1'b0, 1'b0);
        @(negedge CLK); look("alu.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK);

        // Reset during FETCH EXEC1.
        issue(3'd5, 3'd2, 3'd0, 3'd3);
        @(negedge CLK); cmd.CMD_VALID = 1'b0;
        look("rfetch.e1", 10'b1111010011, sw(0, 0, 0, 0, 2, 0, 0), 1'b0, 1'b0);
        RST_bar = 1'b0;
        #1 look("rfetch.async", B_IDLE, S_ZERO, 1'b1, 1'b0);
        @(negedge CLK); look("rfetch.held", B_IDLE, S_ZERO, 1'b1, 1'b0);
        RST_bar = 1'b1;
        @(negedge CLK); look("rfetch.rel", B_IDLE, S_ZERO, 1'b1, 1'b0);
        @(negedge CLK); look("rfetch.nodone", B_IDLE, S_ZERO, 1'b1, 1'b0);

        // Op 7.
        issue(3'd7, 3'd1, 3'd2, 3'd3);
`ifdef REGSEQ_ILLEGAL_TRAP_EN
        @(negedge CLK);
        look("trap.e1", B_IDLE, S_ZERO, 1'b0, 1'b0);
        chk("trap.illegal", {31'd0, ILLEGAL}, 32'd1);
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            chk("trap.ready", {31'd0, cmd.CMD_READY}, 32'd0);
            chk("trap.done", {31'd0, DONE}, 32'd0);
            chk("trap.sticky", {31'd0, ILLEGAL}, 32'd1);
        end
        cmd.CMD_VALID = 1'b0;
        RST_bar = 1'b0;
        #1 chk("trap.clr", {31'd0, ILLEGAL}, 32'd0);
        chk("trap.rdy", {31'd0, cmd.CMD_READY}, 32'd1);
        @(negedge CLK); RST_bar = 1'b1;
        @(negedge CLK);
`else
        @(negedge CLK); cmd.CMD_VALID = 1'b0;
        look("op7.e1", B_IDLE, S_ZERO, 1'b0, 1'b0);
        chk("op7.illegal", {31'd0, ILLEGAL}, 32'd0);
        @(negedge CLK); look("op7.done", B_IDLE, S_ZERO, 1'b0, 1'b1);
        @(negedge CLK); look("op7.idle", B_IDLE, S_ZERO, 1'b1, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/regfile_sequencer.md
# regfile_sequencer

Command-driven control sequencer that drives the register file's active-low assert/load enables, 3-bit selects and address-increment lines. It sits between the instruction decoder and the register file. It accepts one register-transfer command per valid/ready handshake and expands it into a 1- or 2-cycle sequence of registered control strobes. It also drives the memory and ALU bus strobes those transfers need.

## Interface
- No parameters.
- CLK  in  1  system clock; all state changes on the rising edge.
- RST_bar  in  1  asynchronous, active-low reset.
- CMD_VALID  in  1  command present.
- CMD_READY  out  1  sequencer can accept a command.
- CMD_OP  in  3  operation code (see Operation).
- CMD_SRC  in  3  source register index.
- CMD_SRC2  in  3  second source register index.
- CMD_DST  in  3  destination register index.
- DONE  out  1  one-cycle pulse after the last control cycle of a command.
- ILLEGAL  out  1  sticky illegal-op flag (only with REGSEQ_ILLEGAL_TRAP_EN).
- MAIN_ASSERT_bar, MAIN_LOAD_bar, LHS_ASSERT_bar, RHS_ASSERT_bar, ADDR_ASSERT_bar, ADDR_LOAD_bar  out  1 each  register file enables, active low.
- ADDR_INC  out  1  address increment enable, active high.
- MAIN_ASSERT_SEL, MAIN_LOAD_SEL, LHS_ASSERT_SEL, RHS_ASSERT_SEL, ADDR_ASSERT_SEL, ADDR_LOAD_SEL, ADDR_INC_SEL  out  3 each  register selects.
- MEM_READ_bar  out  1  memory drives MAIN bus, active low.
- MEM_WRITE_bar  out  1  memory write strobe, active low.
- ALU_ASSERT_bar  out  1  ALU result drives MAIN bus, active low.

## Operation
- Reset values:
  - All *_bar outputs 1.
  - ADDR_INC, DONE and ILLEGAL are 0.
  - All selects are 0.
  - CMD_READY is 1.
  - State is IDLE.
- States:
  - IDLE: CMD_READY=1, no strobes.
  - EXEC1: first control cycle.
  - EXEC2: second control cycle, 2-cycle ops only.
  - DONE: DONE=1, no strobes, CMD_READY=0.
  - Transitions: DONE always returns to IDLE. With the trap macro, a TRAP state is added.
- Acceptance: a command is latched (op, src, src2, dst) on a rising edge when CMD_VALID=1 and CMD_READY=1. CMD_* inputs are ignored at all other times.
- Operations. Enables are shown in EXEC order. Any enable not listed is inactive, and its select is 0.
  - 0 NOP: EXEC1 with no strobes.
  - 1 MOV8:
    - EXEC1: MAIN_ASSERT sel=src, MAIN_LOAD sel=dst.
    - src==dst is legal.
  - 2 MOV16: EXEC1: ADDR_ASSERT sel=src, ADDR_LOAD sel=dst.
  - 3 INC16: EXEC1: ADDR_INC=1, ADDR_INC_SEL=dst.
  - 4 ALU: EXEC1: LHS_ASSERT sel=src, RHS_ASSERT sel=src2, ALU_ASSERT_bar=0, MAIN_LOAD sel=dst.
  - 5 FETCH:
    - EXEC1: ADDR_ASSERT sel=src, MEM_READ_bar=0.
    - EXEC2: the EXEC1 strobes are held, plus MAIN_LOAD sel=dst, ADDR_INC=1, ADDR_INC_SEL=src (post-increment).
  - 6 STORE:
    - EXEC1: ADDR_ASSERT sel=src, MAIN_ASSERT sel=src2.
    - EXEC2: the EXEC1 strobes are held, plus MEM_WRITE_bar=0.
  - 7 reserved: handled per Configuration.
- Selects pass through as 3 bits unchanged. Indices 4–7 decode to unpopulated register slots and are not errors.
- At most one source drives MAIN in any cycle: MAIN_ASSERT, MEM_READ or ALU_ASSERT. This is guaranteed by the op table.

## Timing
- All outputs come from flops; no combinational path from inputs to outputs.
- Latency: strobes appear in the cycle after acceptance.
  - 1-cycle ops: accept edge → EXEC1 → DONE → IDLE, 3 cycles per command.
  - 2-cycle ops: 4 cycles per command.
- The register file captures at the rising edge that ends the EXEC cycle carrying the load or increment strobe.
- Selects for an enable become valid in the same cycle the enable goes low.
- CMD_VALID held high continuously: the next command is accepted on the edge leaving IDLE. There is no back-to-back acceptance during EXEC or DONE.
- Reset asserted mid-command: all strobes return to their reset values immediately (asynchronously). The in-flight command is discarded and DONE is not pulsed.

## Configuration
- REGSEQ_ILLEGAL_TRAP_EN defined:
  - Op 7 sets ILLEGAL=1 in the cycle after acceptance and enters TRAP.
  - In TRAP, CMD_READY=0, no strobes are driven and DONE is never pulsed.
  - Only RST_bar exits TRAP.
- REGSEQ_ILLEGAL_TRAP_EN not defined: op 7 executes as NOP (including the DONE pulse), and ILLEGAL is tied to 0.

## Test plan
- Reset with CMD_VALID=1: outputs match the reset values; CMD_READY=1 after release; first accept on the first edge.
- MOV8 src=2 dst=1:
  - Next cycle: MAIN_ASSERT_bar=0, MAIN_ASSERT_SEL=2, MAIN_LOAD_bar=0, MAIN_LOAD_SEL=1.
  - DONE one cycle later; CMD_READY=1 one cycle after DONE.
- FETCH src=0 dst=3:
  - EXEC1: ADDR_ASSERT_SEL=0, MEM_READ_bar=0.
  - EXEC2: additionally MAIN_LOAD_SEL=3, ADDR_INC=1, ADDR_INC_SEL=0.
  - DONE on the 3rd cycle after the accept edge.
- STORE src=1 src2=2: MEM_WRITE_bar=0 only in EXEC2, with ADDR_ASSERT_SEL=1 and MAIN_ASSERT_SEL=2 in both cycles.
- Drop RST_bar during FETCH EXEC1: all strobes inactive immediately, no DONE, CMD_READY=1 after release.
- Op 7:
  - With the macro: ILLEGAL=1, CMD_READY stays 0 for 20 cycles, cleared only by reset.
  - Without the macro: behaves as NOP with a DONE pulse.
